// File: rtl/maf_pkg.sv
// Shared definitions for the single-precision MAF datapath.
// Holds the field widths, the mode encodings and the per-beat sideband
// bundle that travels alongside the addend through the aligner. The
// difference and adder stages use the same bundle.
package maf_pkg;

  localparam int MAN_W   = 24;
  localparam int ALIGN_W = 3 * MAN_W + 2;

  localparam logic [2:0] MODE1 = 3'b000;
  localparam logic [2:0] MODE2 = 3'b001;

  // Sideband that rides with one addend beat.
  typedef struct packed {
    logic       eff_sub;   // effective subtraction (already masked in mode 2)
    logic [7:0] sdiff;     // exponent difference, passed through untouched
    logic [2:0] cont;      // mode field, passed through untouched
    logic       clamp_lo;  // shift count was negative, forced to 0
    logic       clamp_hi;  // shift count beyond the field, data zeroed
    logic       unsup;     // mode 2 beat, data fields forced to 0
  } align_beat_t;

  // Mode 2 beats are carried through the pipe but produce no data.
  function automatic logic is_mode2(input logic [2:0] cont);
    return (cont == MODE2);
  endfunction

endpackage

// File: rtl/maf_addend_aligner_align_shift_stage.sv
// One pipeline stage of the addend aligner: a right shift by
// amt_i * GRAN, OR-reduction of the bits pushed past bit 0 into the
// running sticky, and a valid/ready register holding the result.
// With INV set the stage also applies the effective-subtraction
// one's complement and produces the adder carry-in.
//
// Ports:
//   clk, rstn            clock, async active-low reset
//   in_valid / in_ready  upstream handshake (in_ready = stage can load)
//   data_i, sticky_i     field and sticky arriving from upstream
//   amt_i                shift amount in units of GRAN
//   beat_i / beat_o      sideband bundle, registered with the data
//   out_valid/out_ready  downstream handshake
//   data_o, sticky_o     registered field and accumulated sticky
//   cin_o                registered carry-in (meaningful only with INV)
module align_shift_stage
  import maf_pkg::*;
#(
  parameter int W    = ALIGN_W,
  parameter int GRAN = 8,
  parameter int SH_W = 4,
  parameter bit INV  = 1'b0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    data_i,
  input  logic            sticky_i,
  input  logic [SH_W-1:0] amt_i,
  input  align_beat_t     beat_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    data_o,
  output logic            sticky_o,
  output logic            cin_o,
  output align_beat_t     beat_o
);

  localparam logic [6:0] GRAN_L = 7'(GRAN);

  logic [6:0]   sh_s;
  logic [W-1:0] shifted_s;
  logic [W-1:0] mask_s;
  logic [W-1:0] data_n_s;
  logic         dropped_s;
  logic         sticky_n_s;
  logic         inv_s;
  logic         cin_n_s;
  logic         load_s;
  logic         valid_r;

  // The stage may load whenever it is empty or its content leaves this cycle.
  assign load_s    = ~valid_r | out_ready;
  assign in_ready  = load_s;
  assign out_valid = valid_r;

  // Shift, collect dropped bits into sticky, optional complement and carry-in.
  always_comb begin
    sh_s       = 7'(amt_i) * GRAN_L;
    shifted_s  = data_i >> sh_s;
    // Low sh_s bits are exactly the ones that fall off the right end.
    mask_s     = ~({W{1'b1}} << sh_s);
    dropped_s  = |(data_i & mask_s);
    sticky_n_s = sticky_i | dropped_s;
    if (INV) begin
      inv_s = beat_i.eff_sub;
    end else begin
      inv_s = 1'b0;
    end
    data_n_s = shifted_s ^ {W{inv_s}};
    // The +1 of the two's complement is only needed when nothing was
    // shifted out; otherwise the sticky bit absorbs it.
    cin_n_s  = inv_s & ~sticky_n_s;
  end

  // Stage occupancy flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_r <= 1'b0;
    end else if (load_s) begin
      valid_r <= in_valid;
    end
  end

  // Payload register, written only on an accepted beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_o   <= {W{1'b0}};
      sticky_o <= 1'b0;
      cin_o    <= 1'b0;
      beat_o   <= '{eff_sub: 1'b0, sdiff: 8'h00, cont: 3'b000,
                    clamp_lo: 1'b0, clamp_hi: 1'b0, unsup: 1'b0};
    end else if (load_s && in_valid) begin
      data_o   <= data_n_s;
      sticky_o <= sticky_n_s;
      cin_o    <= cin_n_s;
      beat_o   <= beat_i;
    end
  end

endmodule

// File: rtl/maf_addend_aligner.sv
// Addend aligner of the single-precision MAF datapath. Places the C
// mantissa at the top of the 74-bit alignment field and right-shifts it
// by the alignment count in two registered steps (coarse by 8, fine by
// 1), producing the aligned addend, sticky and carry-in for the adder.
//
// Ports:
//   clk, rstn             clock, async active-low reset
//   in_valid / in_ready   input handshake
//   man_c                 C mantissa, hidden bit at the MSB
//   eff_sub               effective subtraction
//   asc                   alignment shift count, two's complement
//   sdiff, cont           exponent difference and mode, passed through
//   out_valid / out_ready output handshake
//   aligned, sticky, cin  aligned addend (complemented if eff_sub),
//                         sticky bit, adder carry-in
//   sdiff_o, cont_o       pass-through fields delayed with their beat
//   clamp_lo, clamp_hi    shift count clamped at 0 / beyond the field
//   unsup                 mode 2 beat, data forced to 0
module maf_addend_aligner
  import maf_pkg::*;
#(
  parameter int MAN_W   = maf_pkg::MAN_W,
  parameter int ALIGN_W = maf_pkg::ALIGN_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAN_W-1:0]   man_c,
  input  logic               eff_sub,
  input  logic [7:0]         asc,
  input  logic [7:0]         sdiff,
  input  logic [2:0]         cont,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALIGN_W-1:0] aligned,
  output logic               sticky,
  output logic               cin,
  output logic [7:0]         sdiff_o,
  output logic [2:0]         cont_o,
  output logic               clamp_lo,
  output logic               clamp_hi,
  output logic               unsup
);

  localparam logic [6:0] LIM_L = 7'(ALIGN_W);
  localparam int         PAD_W = ALIGN_W - MAN_W;

  logic               neg_s;
  logic               hi_s;
  logic               unsup_s;
  logic [6:0]         s_s;
  logic [MAN_W-1:0]   man_eff_s;
  logic [ALIGN_W-1:0] data0_s;
  logic               sticky0_s;
  align_beat_t        beat0_s;

  logic [2:0]         fine_r;
  logic               v1_s;
  logic               rdy2_s;
  logic [ALIGN_W-1:0] data1_s;
  logic               sticky1_s;
  logic               cin1_s;
  align_beat_t        beat1_s;
  align_beat_t        beat2_s;
  logic               unused_s;

  // Decode the shift count and build the unshifted field and sideband.
  always_comb begin
    neg_s   = asc[7];
    hi_s    = ~asc[7] & (asc[6:0] >= LIM_L);
    unsup_s = is_mode2(cont);
    if (neg_s || hi_s) begin
      s_s = 7'd0;
    end else begin
      s_s = asc[6:0];
    end
    // Out-of-range and mode 2 beats enter the pipe with an empty field.
    if (unsup_s || hi_s) begin
      man_eff_s = {MAN_W{1'b0}};
    end else begin
      man_eff_s = man_c;
    end
    data0_s   = {man_eff_s, {PAD_W{1'b0}}};
    // Everything is shifted out when the count is beyond the field.
    sticky0_s = hi_s & ~unsup_s & (|man_c);
    beat0_s.eff_sub  = eff_sub & ~unsup_s;
    beat0_s.sdiff    = sdiff;
    beat0_s.cont     = cont;
    beat0_s.clamp_lo = neg_s;
    beat0_s.clamp_hi = hi_s;
    beat0_s.unsup    = unsup_s;
  end

  // Fine shift amount travels beside the coarse stage, loaded with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fine_r <= 3'd0;
    end else if (in_valid && in_ready) begin
      fine_r <= s_s[2:0];
    end
  end

  align_shift_stage #(
    .W    (ALIGN_W),
    .GRAN (8),
    .SH_W (4),
    .INV  (1'b0)
  ) u_coarse (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_i    (data0_s),
    .sticky_i  (sticky0_s),
    .amt_i     (s_s[6:3]),
    .beat_i    (beat0_s),
    .out_valid (v1_s),
    .out_ready (rdy2_s),
    .data_o    (data1_s),
    .sticky_o  (sticky1_s),
    .cin_o     (cin1_s),
    .beat_o    (beat1_s)
  );

  align_shift_stage #(
    .W    (ALIGN_W),
    .GRAN (1),
    .SH_W (3),
    .INV  (1'b1)
  ) u_fine (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (v1_s),
    .in_ready  (rdy2_s),
    .data_i    (data1_s),
    .sticky_i  (sticky1_s),
    .amt_i     (fine_r),
    .beat_i    (beat1_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_o    (aligned),
    .sticky_o  (sticky),
    .cin_o     (cin),
    .beat_o    (beat2_s)
  );

  assign sdiff_o  = beat2_s.sdiff;
  assign cont_o   = beat2_s.cont;
  assign clamp_lo = beat2_s.clamp_lo;
  assign clamp_hi = beat2_s.clamp_hi;
  assign unsup    = beat2_s.unsup;

  // Coarse-stage carry-in and final eff_sub have no consumer downstream.
  assign unused_s = ^{cin1_s, beat2_s.eff_sub};

endmodule

// File: tb/tb_maf_addend_aligner.sv
module tb_maf_addend_aligner;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] man_c;
  logic        eff_sub;
  logic [7:0]  asc;
  logic [7:0]  sdiff;
  logic [2:0]  cont;
  logic        out_valid;
  logic        out_ready;
  logic [73:0] aligned;
  logic        sticky;
  logic        cin;
  logic [7:0]  sdiff_o;
  logic [2:0]  cont_o;
  logic        clamp_lo;
  logic        clamp_hi;
  logic        unsup;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maf_addend_aligner dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .man_c     (man_c),
    .eff_sub   (eff_sub),
    .asc       (asc),
    .sdiff     (sdiff),
    .cont      (cont),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aligned   (aligned),
    .sticky    (sticky),
    .cin       (cin),
    .sdiff_o   (sdiff_o),
    .cont_o    (cont_o),
    .clamp_lo  (clamp_lo),
    .clamp_hi  (clamp_hi),
    .unsup     (unsup)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Reference: one wide shift of {man, zeros} keeps the field in the top
  // 74 bits and everything shifted past bit 0 in the low 74 bits.
  function automatic logic [89:0] model(input logic [23:0] man, input logic e,
                                        input logic [7:0] a, input logic [7:0] sd,
                                        input logic [2:0] ct);
    logic [147:0] wide;
    logic [73:0]  al;
    logic         st, lo, hi, un, ci;
    lo   = a[7];
    hi   = !a[7] && (a >= 8'd74);
    un   = (ct == 3'b001);
    wide = {man, 124'd0};
    if (!lo && !hi) wide = wide >> a;
    al = wide[147:74];
    st = |wide[73:0];
    if (hi) begin al = 74'd0; st = |man; end
    if (un) begin al = 74'd0; st = 1'b0; end
    if (e && !un) al = ~al;
    ci = e && !un && !st;
    return {al, st, ci, lo, hi, un, sd, ct};
  endfunction

  function automatic logic [89:0] obs();
    return {aligned, sticky, cin, clamp_lo, clamp_hi, unsup, sdiff_o, cont_o};
  endfunction

  // Drive one beat at a negedge with out_ready high and check the result
  // against hand-computed values two clock edges later.
  task automatic run_vec(input string tag, input logic [23:0] man, input logic e,
                         input logic [7:0] a, input logic [7:0] sd, input logic [2:0] ct,
                         input logic [73:0] exp_al, input logic exp_st, input logic exp_ci,
                         input logic [2:0] exp_flags);
    man_c = man; eff_sub = e; asc = a; sdiff = sd; cont = ct;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; man_c = 24'h5A5A5A; asc = 8'h33; sdiff = 8'hEE; cont = 3'b111;
    chk({tag, "/lat1_valid"}, 128'(out_valid), 128'(1'b0));
    @(negedge clk);
    chk({tag, "/valid"}, 128'(out_valid), 128'(1'b1));
    chk({tag, "/aligned"}, 128'(aligned), 128'(exp_al));
    chk({tag, "/sticky"}, 128'(sticky), 128'(exp_st));
    chk({tag, "/cin"}, 128'(cin), 128'(exp_ci));
    chk({tag, "/flags"}, 128'({clamp_lo, clamp_hi, unsup}), 128'(exp_flags));
    chk({tag, "/sdiff_o"}, 128'(sdiff_o), 128'(sd));
    chk({tag, "/cont_o"}, 128'(cont_o), 128'(ct));
    @(negedge clk);
    chk({tag, "/drained"}, 128'(out_valid), 128'(1'b0));
  endtask

  logic [23:0] s_man [6] = '{24'hABCDEF, 24'h800001, 24'hFFFFFF, 24'h123457, 24'hC00001, 24'h800000};
  logic [7:0]  s_asc [6] = '{8'd0, 8'd8, 8'd9, 8'd50, 8'd73, 8'd74};
  logic [89:0] exp_q [6];
  // out_ready per stream cycle, bit 0 first; contains two 3-cycle stalls.
  logic [15:0] rdy_pat = 16'b1000110110100011;

  initial begin
    int          nin, nout, infl;
    logic [89:0] cur, prev;
    logic        prev_stall, acc, emt;

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    man_c = 24'd0; eff_sub = 1'b0; asc = 8'd0; sdiff = 8'd0; cont = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset/out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset/in_ready", 128'(in_ready), 128'(1'b1));
    chk("reset/aligned", 128'(aligned), 128'(74'd0));
    chk("reset/flags", 128'({sticky, cin, clamp_lo, clamp_hi, unsup}), 128'(5'd0));
    chk("reset/sdiff_o", 128'(sdiff_o), 128'(8'd0));
    rstn = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed results.
    run_vec("shift0", 24'h800000, 1'b0, 8'd0, 8'h12, 3'b000,
            74'd1 << 73, 1'b0, 1'b0, 3'b000);
    run_vec("shift73_sub", 24'hC00001, 1'b1, 8'd73, 8'h34, 3'b010,
            ~74'd1, 1'b1, 1'b0, 3'b000);
    run_vec("neg_clamp", 24'h800000, 1'b0, 8'hF0, 8'h56, 3'b000,
            74'd1 << 73, 1'b0, 1'b0, 3'b100);
    run_vec("hi_clamp", 24'h800001, 1'b0, 8'd100, 8'h78, 3'b000,
            74'd0, 1'b1, 1'b0, 3'b010);
    run_vec("mode2", 24'hFFFFFF, 1'b1, 8'd5, 8'hA5, 3'b001,
            74'd0, 1'b0, 1'b0, 3'b001);
    run_vec("zero_man_sub", 24'h000000, 1'b1, 8'd10, 8'h01, 3'b000,
            {74{1'b1}}, 1'b0, 1'b1, 3'b000);
    run_vec("shift9", 24'h800001, 1'b0, 8'd9, 8'h02, 3'b000,
            (74'd1 << 64) | (74'd1 << 41), 1'b0, 1'b0, 3'b000);

    // Streaming with backpressure.
    for (int i = 0; i < 6; i++)
      exp_q[i] = model(s_man[i], i[0], s_asc[i], 8'(i * 17), (i == 2) ? 3'b101 : 3'b000);
    nin = 0; nout = 0; infl = 0; prev_stall = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 80 && nout < 6; cyc++) begin
      cur = obs();
      if (prev_stall) begin
        chk("stall/valid", 128'(out_valid), 128'(1'b1));
        chk("stall/hold", 128'(cur), 128'(prev));
      end
      if (nin < 6) begin
        in_valid = 1'b1; man_c = s_man[nin]; eff_sub = nin[0]; asc = s_asc[nin];
        sdiff = 8'(nin * 17); cont = (nin == 2) ? 3'b101 : 3'b000;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (cyc < 16) ? rdy_pat[cyc] : 1'b1;
      #1;
      chk("stream/in_ready", 128'(in_ready), 128'(!(infl == 2 && !out_ready)));
      acc = in_valid & in_ready;
      emt = out_valid & out_ready;
      if (emt) begin
        if (nout < 6) chk($sformatf("stream/beat%0d", nout), 128'(cur), 128'(exp_q[nout]));
        else chk("stream/extra", 128'(out_valid), 128'(1'b0));
        nout++;
      end
      prev_stall = out_valid & ~out_ready;
      prev = cur;
      if (acc) nin++;
      infl = infl + (acc ? 1 : 0) - (emt ? 1 : 0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream/count", 128'(nout), 128'(6));
    @(negedge clk);
    chk("stream/idle", 128'(out_valid), 128'(1'b0));

    // Reset with two beats in flight.
    out_ready = 1'b0;
    man_c = 24'h800000; eff_sub = 1'b0; asc = 8'd0; sdiff = 8'h11; cont = 3'b000; in_valid = 1'b1;
    @(negedge clk);
    man_c = 24'hFFFFFF; asc = 8'd3; sdiff = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_mid/full", 128'({out_valid, in_ready}), 128'(2'b10));
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid/out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_mid/in_ready", 128'(in_ready), 128'(1'b1));
    @(negedge clk);
    rstn = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid/quiet%0d", k), 128'(out_valid), 128'(1'b0));
    end
    run_vec("after_rst", 24'hC00000, 1'b1, 8'd1, 8'h99, 3'b011,
            ~((74'd3 << 72) >> 1), 1'b0, 1'b1, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
